// File: rtl/afifo_rd_packer.sv
// afifo_rd_packer: pops narrow words from the async FIFO read port and
// packs them, lane 0 first, into wide words on a valid/ready stream.
module afifo_rd_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PACK_RATIO     = 4,
  parameter int LANE_CNT_WIDTH = 3,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_WIDTH  = 5
) (
  input  logic                             Clk,
  input  logic                             Reset_in,
  input  logic [DATA_WIDTH-1:0]            FifoData_in,
  input  logic                             FifoEmpty_in,
  output logic                             FifoReadEn_out,
  input  logic                             Flush_in,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] Word_out,
  output logic [LANE_CNT_WIDTH-1:0]        WordCount_out,
  output logic                             WordValid_out,
  input  logic                             WordReady_in
);

  localparam int WW  = DATA_WIDTH * PACK_RATIO;
  localparam int CW1 = LANE_CNT_WIDTH + 1;
  localparam logic [LANE_CNT_WIDTH-1:0] LAST_LANE =
    LANE_CNT_WIDTH'(PACK_RATIO - 1);
  localparam logic [LANE_CNT_WIDTH-1:0] FULL_CNT =
    LANE_CNT_WIDTH'(PACK_RATIO);
  localparam logic [CW1-1:0] LANE_LIMIT = CW1'(PACK_RATIO);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST =
    TIMEOUT_WIDTH'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  logic [WW-1:0]             r_asm;
  logic [LANE_CNT_WIDTH-1:0] r_lane_idx;
  logic                      r_rd_pending;
  logic                      r_flush_req;
  logic                      r_asm_full;
  logic [TIMEOUT_WIDTH-1:0]  r_idle_cnt;
  logic [WW-1:0]             r_word;
  logic [LANE_CNT_WIDTH-1:0] r_count;
  logic                      r_valid;

  logic [CW1-1:0] w_inflight;
  logic           w_rd_en;
  logic           w_out_free;
  logic           w_land;
  logic           w_last;
  logic           w_emit_asm;
  logic           w_emit_land;
  logic           w_flush_go;
  logic           w_emit_part;
  logic           w_idle;
  logic           w_to_hit;
  logic [WW-1:0]  w_full_word;
  logic [WW-1:0]  w_part_word;

  // Reads may not outrun the assembly register: landed plus in-flight
  // lanes must stay below one full word.
  assign w_inflight = {1'b0, r_lane_idx} + CW1'(r_rd_pending);
  assign w_rd_en = !FifoEmpty_in & !r_flush_req & !r_asm_full &
                   (w_inflight < LANE_LIMIT);
  assign FifoReadEn_out = w_rd_en & !Reset_in;

  assign w_out_free  = !r_valid | WordReady_in;
  assign w_land      = r_rd_pending;
  assign w_last      = w_land & (r_lane_idx == LAST_LANE);
  assign w_emit_asm  = r_asm_full & w_out_free;
  assign w_emit_land = w_last & w_out_free;
  assign w_flush_go  = r_flush_req & !r_rd_pending & !r_asm_full &
                       w_out_free;
  assign w_emit_part = w_flush_go & (r_lane_idx != '0);
  assign w_idle      = (r_lane_idx != '0) & !w_rd_en & !r_rd_pending;
  assign w_to_hit    = TO_EN & w_idle & (r_idle_cnt == TO_LAST);

  // Full word with the arriving top lane bypassed straight in.
  always_comb begin
    w_full_word = r_asm;
    w_full_word[WW-1 -: DATA_WIDTH] = FifoData_in;
  end

  // Partial word: lanes at or above lane_idx are stale, so zero them.
  always_comb begin
    w_part_word = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (LANE_CNT_WIDTH'(i) < r_lane_idx) begin
        w_part_word[i*DATA_WIDTH +: DATA_WIDTH] =
          r_asm[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Lane assembly: landing data, lane index and parked-word tracking.
  always_ff @(posedge Clk or posedge Reset_in) begin
    if (Reset_in) begin
      r_asm        <= '0;
      r_lane_idx   <= '0;
      r_rd_pending <= 1'b0;
      r_asm_full   <= 1'b0;
    end else begin
      r_rd_pending <= w_rd_en;
      if (w_land) begin
        for (int i = 0; i < PACK_RATIO; i++) begin
          if (r_lane_idx == LANE_CNT_WIDTH'(i)) begin
            r_asm[i*DATA_WIDTH +: DATA_WIDTH] <= FifoData_in;
          end
        end
        if (w_last) begin
          r_lane_idx <= '0;
          if (!w_out_free) begin
            r_asm_full <= 1'b1;
          end
        end else begin
          r_lane_idx <= r_lane_idx + LANE_CNT_WIDTH'(1);
        end
      end else if (w_emit_asm) begin
        r_asm_full <= 1'b0;
      end else if (w_flush_go) begin
        r_lane_idx <= '0;
      end
    end
  end

  // Sticky flush request and idle timeout that raises it.
  always_ff @(posedge Clk or posedge Reset_in) begin
    if (Reset_in) begin
      r_flush_req <= 1'b0;
      r_idle_cnt  <= '0;
    end else begin
      if (Flush_in | w_to_hit) begin
        r_flush_req <= 1'b1;
      end else if (w_flush_go) begin
        r_flush_req <= 1'b0;
      end
      if (w_land | (r_lane_idx == '0)) begin
        r_idle_cnt <= '0;
      end else if (w_idle & !r_flush_req) begin
        r_idle_cnt <= r_idle_cnt + TIMEOUT_WIDTH'(1);
      end
    end
  end

  // Output register: parked word first, then a landing word, then flush.
  always_ff @(posedge Clk or posedge Reset_in) begin
    if (Reset_in) begin
      r_word  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_emit_asm) begin
        r_word  <= r_asm;
        r_count <= FULL_CNT;
        r_valid <= 1'b1;
      end else if (w_emit_land) begin
        r_word  <= w_full_word;
        r_count <= FULL_CNT;
        r_valid <= 1'b1;
      end else if (w_emit_part) begin
        r_word  <= w_part_word;
        r_count <= r_lane_idx;
        r_valid <= 1'b1;
      end else if (WordReady_in) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign Word_out      = r_word;
  assign WordCount_out = r_count;
  assign WordValid_out = r_valid;

endmodule

// File: tb/tb_afifo_rd_packer.sv
// tb_afifo_rd_packer: scenario tasks with a queue-based FIFO model and
// a byte-grouping reference model for the packed output stream.
module tb_afifo_rd_packer;

  localparam int DW = 8;
  localparam int PR = 4;
  localparam int LW = 3;
  localparam int TO = 16;
  localparam int WW = DW * PR;
  localparam int MD = 2048;

  logic Clk = 1'b0;
  logic rst = 1'b1;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // DUT A: timeout enabled
  logic [DW-1:0] fdata_a = '0;
  logic          empty_a;
  logic          rd_a;
  logic          flush_a = 1'b0;
  logic          rdy_a = 1'b1;
  logic [WW-1:0] word_a;
  logic [LW-1:0] cnt_a;
  logic          vld_a;
  logic [DW-1:0] mem_a [MD];
  int pushed_a = 0;
  int popped_a = 0;

  assign empty_a = (pushed_a == popped_a);

  // FIFO model: data valid one cycle after the read; reset clears it
  always @(posedge Clk or posedge rst) begin
    if (rst) begin
      popped_a <= pushed_a;
    end else if (rd_a && !empty_a) begin
      fdata_a  <= mem_a[popped_a % MD];
      popped_a <= popped_a + 1;
    end
  end

  afifo_rd_packer #(
    .DATA_WIDTH(DW), .PACK_RATIO(PR), .LANE_CNT_WIDTH(LW),
    .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(5)
  ) u_dut_a (
    .Clk(Clk), .Reset_in(rst),
    .FifoData_in(fdata_a), .FifoEmpty_in(empty_a),
    .FifoReadEn_out(rd_a), .Flush_in(flush_a),
    .Word_out(word_a), .WordCount_out(cnt_a),
    .WordValid_out(vld_a), .WordReady_in(rdy_a)
  );

  // DUT B: timeout disabled
  logic [DW-1:0] fdata_b = '0;
  logic          empty_b;
  logic          rd_b;
  logic          flush_b = 1'b0;
  logic          rdy_b = 1'b1;
  logic [WW-1:0] word_b;
  logic [LW-1:0] cnt_b;
  logic          vld_b;
  logic [DW-1:0] mem_b [MD];
  int pushed_b = 0;
  int popped_b = 0;

  assign empty_b = (pushed_b == popped_b);

  // FIFO model for DUT B
  always @(posedge Clk or posedge rst) begin
    if (rst) begin
      popped_b <= pushed_b;
    end else if (rd_b && !empty_b) begin
      fdata_b  <= mem_b[popped_b % MD];
      popped_b <= popped_b + 1;
    end
  end

  afifo_rd_packer #(
    .DATA_WIDTH(DW), .PACK_RATIO(PR), .LANE_CNT_WIDTH(LW),
    .TIMEOUT_CYCLES(0), .TIMEOUT_WIDTH(5)
  ) u_dut_b (
    .Clk(Clk), .Reset_in(rst),
    .FifoData_in(fdata_b), .FifoEmpty_in(empty_b),
    .FifoReadEn_out(rd_b), .Flush_in(flush_b),
    .Word_out(word_b), .WordCount_out(cnt_b),
    .WordValid_out(vld_b), .WordReady_in(rdy_b)
  );

  // Transfer monitor for DUT A
  logic [WW-1:0] obs_w [$];
  logic [LW-1:0] obs_c [$];
  always @(posedge Clk) begin
    if (!rst && vld_a && rdy_a) begin
      obs_w.push_back(word_a);
      obs_c.push_back(cnt_a);
    end
  end

  task automatic cyc();
    @(negedge Clk);
    #1;
  endtask

  task automatic push_a(input logic [DW-1:0] b);
    mem_a[pushed_a % MD] = b;
    pushed_a = pushed_a + 1;
  endtask

  task automatic push_b(input logic [DW-1:0] b);
    mem_b[pushed_b % MD] = b;
    pushed_b = pushed_b + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    push_a(8'h99);
    #1;
    checks++;
    if (vld_a !== 1'b0 || word_a !== '0 || cnt_a !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b w=%h c=%0d want 0",
               vld_a, word_a, cnt_a);
    end
    checks++;
    if (rd_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_rden got %b want 0 (fifo not empty)", rd_a);
    end
    checks++;
    if (vld_b !== 1'b0 || word_b !== '0 || cnt_b !== '0) begin
      errors++;
      $display("FAIL reset_outputs_b got v=%b w=%h c=%0d want 0",
               vld_b, word_b, cnt_b);
    end
    cyc();
    rst = 1'b0;
    cyc();
    #1;
    checks++;
    if (rd_a !== 1'b0 || vld_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo_cleared got rd=%b v=%b want 0 0",
               rd_a, vld_a);
    end
  endtask

  task automatic test_basic();
    int first_rd = -1;
    int last_rd = -1;
    int nrd = 0;
    int first_v = -1;
    int nv = 0;
    logic [WW-1:0] w = '0;
    logic [LW-1:0] c = '0;
    rdy_a = 1'b1;
    cyc();
    push_a(8'h11); push_a(8'h22); push_a(8'h33); push_a(8'h44);
    for (int i = 0; i < 14; i++) begin
      if (i > 0) cyc();
      #1;
      if (rd_a) begin
        if (first_rd < 0) first_rd = i;
        last_rd = i;
        nrd++;
      end
      if (vld_a) begin
        if (first_v < 0) begin
          first_v = i; w = word_a; c = cnt_a;
        end
        nv++;
      end
    end
    checks++;
    if (nrd !== 4 || last_rd - first_rd !== 3) begin
      errors++;
      $display("FAIL basic_reads got n=%0d span=%0d want 4 consecutive",
               nrd, last_rd - first_rd + 1);
    end
    checks++;
    if (w !== 32'h44332211 || c !== 3'd4) begin
      errors++;
      $display("FAIL basic_word got %h/%0d want 44332211/4", w, c);
    end
    checks++;
    if (nv !== 1) begin
      errors++;
      $display("FAIL basic_valid_cycles got %0d want 1", nv);
    end
    // last read in cycle first+3 lands one cycle later; visible after
    checks++;
    if (first_v !== first_rd + PR + 1) begin
      errors++;
      $display("FAIL basic_latency got %0d want %0d",
               first_v, first_rd + PR + 1);
    end
  endtask

  task automatic test_backpressure();
    int nrd = 0;
    int bad = 0;
    bit found = 0;
    rdy_a = 1'b0;
    cyc();
    for (int i = 1; i <= 12; i++) push_a(DW'(i));
    for (int i = 0; i < 24; i++) begin
      if (i > 0) cyc();
      #1;
      if (rd_a) nrd++;
      if (vld_a && (word_a !== 32'h04030201 || cnt_a !== 3'd4)) bad++;
    end
    checks++;
    if (nrd !== 8) begin
      errors++;
      $display("FAIL bp_reads got %0d want 8", nrd);
    end
    checks++;
    if (bad !== 0 || vld_a !== 1'b1 || word_a !== 32'h04030201) begin
      errors++;
      $display("FAIL bp_hold got v=%b w=%h bad=%0d want 1 04030201 0",
               vld_a, word_a, bad);
    end
    cyc();
    rdy_a = 1'b1;
    #1;
    cyc();
    #1;
    checks++;
    if (vld_a !== 1'b1 || word_a !== 32'h08070605) begin
      errors++;
      $display("FAIL bp_second got v=%b w=%h want 1 08070605",
               vld_a, word_a);
    end
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      #1;
      if (vld_a && word_a !== 32'h08070605) found = 1;
    end
    checks++;
    if (!found || word_a !== 32'h0C0B0A09 || cnt_a !== 3'd4) begin
      errors++;
      $display("FAIL bp_third got found=%0d w=%h c=%0d want 0C0B0A09/4",
               found, word_a, cnt_a);
    end
    repeat (3) cyc();
  endtask

  task automatic test_flush();
    int nv = 0;
    rdy_a = 1'b1;
    cyc();
    push_a(8'hAA); push_a(8'hBB);
    repeat (4) cyc();
    flush_a = 1'b1;
    #1;
    cyc();
    flush_a = 1'b0;
    #1;
    checks++;
    if (vld_a !== 1'b0) begin
      errors++;
      $display("FAIL flush_early got v=%b want 0", vld_a);
    end
    cyc();
    #1;
    checks++;
    if (vld_a !== 1'b1 || word_a !== 32'h0000BBAA || cnt_a !== 3'd2) begin
      errors++;
      $display("FAIL flush_word got v=%b w=%h c=%0d want 1 0000BBAA 2",
               vld_a, word_a, cnt_a);
    end
    cyc();
    flush_a = 1'b1;
    #1;
    cyc();
    flush_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (vld_a) nv++;
      cyc();
    end
    checks++;
    if (nv !== 0) begin
      errors++;
      $display("FAIL flush_empty got %0d valid cycles want 0", nv);
    end
  endtask

  task automatic test_timeout();
    int first_v = -1;
    int nv = 0;
    int nrd = 0;
    logic [WW-1:0] w = '0;
    logic [LW-1:0] c = '0;
    rdy_a = 1'b1;
    cyc();
    push_a(8'h5A);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) cyc();
      #1;
      if (vld_a && first_v < 0) begin
        first_v = i; w = word_a; c = cnt_a;
      end
    end
    // read in cycle 0, lands at edge closing cycle 1, valid TO+1 edges on
    checks++;
    if (first_v !== 1 + (TO + 1) + 1) begin
      errors++;
      $display("FAIL timeout_latency got %0d want %0d",
               first_v, 1 + (TO + 1) + 1);
    end
    checks++;
    if (w !== 32'h0000005A || c !== 3'd1) begin
      errors++;
      $display("FAIL timeout_word got %h/%0d want 0000005A/1", w, c);
    end
    cyc();
    push_b(8'h5A);
    for (int i = 0; i < 100; i++) begin
      if (i > 0) cyc();
      #1;
      if (vld_b) nv++;
      if (rd_b) nrd++;
    end
    checks++;
    if (nv !== 0 || nrd !== 1) begin
      errors++;
      $display("FAIL timeout_disabled got valid=%0d reads=%0d want 0 1",
               nv, nrd);
    end
  endtask

  task automatic test_flush_last();
    int nv = 0;
    logic [WW-1:0] w = '0;
    logic [LW-1:0] c = '0;
    rdy_a = 1'b1;
    cyc();
    push_a(8'h01); push_a(8'h02); push_a(8'h03); push_a(8'h04);
    for (int i = 0; i < 14; i++) begin
      if (i > 0) cyc();
      flush_a = (i == 4);
      #1;
      if (vld_a) begin
        nv++; w = word_a; c = cnt_a;
      end
    end
    flush_a = 1'b0;
    checks++;
    if (nv !== 1 || w !== 32'h04030201 || c !== 3'd4) begin
      errors++;
      $display("FAIL flush_last got n=%0d w=%h c=%0d want 1 04030201 4",
               nv, w, c);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    logic [WW-1:0] w = '0;
    logic [LW-1:0] c = '0;
    rdy_a = 1'b1;
    cyc();
    push_a(8'h51); push_a(8'h52); push_a(8'h53);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    checks++;
    if (vld_a !== 1'b0 || word_a !== '0 || cnt_a !== '0 || rd_a !== 1'b0)
    begin
      errors++;
      $display("FAIL reset_mid got v=%b w=%h c=%0d rd=%b want all 0",
               vld_a, word_a, cnt_a, rd_a);
    end
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    push_a(8'hA0); push_a(8'hA1); push_a(8'hA2); push_a(8'hA3);
    for (int i = 0; i < 14; i++) begin
      if (i > 0) cyc();
      #1;
      if (vld_a) begin
        nv++; w = word_a; c = cnt_a;
      end
    end
    checks++;
    if (nv !== 1 || w !== 32'hA3A2A1A0 || c !== 3'd4) begin
      errors++;
      $display("FAIL reset_recover got n=%0d w=%h c=%0d want 1 A3A2A1A0 4",
               nv, w, c);
    end
  endtask

  task automatic test_random_stream();
    localparam int NW = 24;
    logic [WW-1:0] exp_q [$];
    logic [WW-1:0] w;
    logic [WW-1:0] pw = '0;
    logic [LW-1:0] pc = '0;
    logic [DW-1:0] b;
    bit pv = 0;
    bit pr = 0;
    int bad = 0;
    int base = obs_w.size();
    cyc();
    for (int k = 0; k < NW; k++) begin
      w = '0;
      for (int l = 0; l < PR; l++) begin
        b = DW'($urandom);
        push_a(b);
        w = w | (WW'(b) << (DW * l));
      end
      exp_q.push_back(w);
    end
    for (int i = 0; i < 3000 && obs_w.size() - base < NW; i++) begin
      if (i > 0) cyc();
      rdy_a = ($urandom_range(0, 3) != 0);
      #1;
      if (pv && !pr &&
          (vld_a !== 1'b1 || word_a !== pw || cnt_a !== pc)) bad++;
      pv = vld_a; pr = rdy_a; pw = word_a; pc = cnt_a;
    end
    rdy_a = 1'b1;
    checks++;
    if (obs_w.size() - base !== NW) begin
      errors++;
      $display("FAIL rand_count got %0d want %0d",
               obs_w.size() - base, NW);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rand_stable got %0d unstable cycles want 0", bad);
    end
    for (int k = 0; k < NW && base + k < obs_w.size(); k++) begin
      checks++;
      if (obs_w[base+k] !== exp_q[k] || obs_c[base+k] !== 3'd4) begin
        errors++;
        $display("FAIL rand_word%0d got %h/%0d want %h/4",
                 k, obs_w[base+k], obs_c[base+k], exp_q[k]);
      end
    end
    repeat (3) cyc();
  endtask

  task automatic test_random_partial();
    rdy_a = 1'b1;
    for (int r = 0; r < 6; r++) begin
      logic [DW-1:0] bytes [$];
      int k = $urandom_range(1, 7);
      int base = obs_w.size();
      int nexp = (k + PR - 1) / PR;
      cyc();
      for (int j = 0; j < k; j++) begin
        bytes.push_back(DW'($urandom));
        push_a(bytes[j]);
      end
      repeat (k + 5) cyc();
      flush_a = 1'b1;
      #1;
      cyc();
      flush_a = 1'b0;
      repeat (6) cyc();
      checks++;
      if (obs_w.size() - base !== nexp) begin
        errors++;
        $display("FAIL part%0d_count got %0d want %0d",
                 r, obs_w.size() - base, nexp);
      end
      for (int g = 0; g < nexp && base + g < obs_w.size(); g++) begin
        logic [WW-1:0] w = '0;
        int n = (k - PR * g < PR) ? k - PR * g : PR;
        for (int l = 0; l < n; l++)
          w = w | (WW'(bytes[PR*g+l]) << (DW * l));
        checks++;
        if (obs_w[base+g] !== w || int'(obs_c[base+g]) !== n) begin
          errors++;
          $display("FAIL part%0d_word%0d got %h/%0d want %h/%0d",
                   r, g, obs_w[base+g], obs_c[base+g], w, n);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_timeout();
    test_flush_last();
    test_reset_mid();
    test_random_stream();
    test_random_partial();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
